pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the ALU result and read-data fields.
REQ-002 SHALL have parameter REG_W, default 5: width of the write-register field.
REQ-003 SHALL have parameter CTRL_W, default 2: width of the control field (mem_to_reg, reg_write).
REQ-004 SHALL have parameter CNT_W, default 16: width of the stall counter.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port hit  input  1  cache hit; gates acceptance of the input beat.
REQ-008 SHALL have port in_valid  input  1  upstream beat valid.
REQ-009 SHALL have port in_ready  output  1  stage can accept a beat.
REQ-010 SHALL have port alu_result  input  DATA_W  ALU result.
REQ-011 SHALL have port read_data  input  DATA_W  data-memory read value.
REQ-012 SHALL have port write_register  input  REG_W  write-back destination.
REQ-013 SHALL have port control  input  CTRL_W  write-back control.
REQ-014 SHALL have port flush  input  1  synchronous squash of all held beats.
REQ-015 SHALL have port out_valid  output  1  head beat valid.
REQ-016 SHALL have port out_ready  input  1  write-back consumes the head beat.
REQ-017 SHALL have ports alu_result_out, read_data_out, write_register_out and control_out as outputs, each the width of its input counterpart, carrying the head beat.
REQ-018 SHALL have port stall_cnt  output  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Function
REQ-019 Storage SHALL be two entries, main (head) and skid, tracked by occupancy state EMPTY(0), ONE(1) and TWO(2).
REQ-020 Push SHALL occur when in_valid && hit && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-021 in_ready SHALL equal (state != TWO), decoded from registered state only, with no combinational path from out_ready or in_valid.
REQ-022 out_valid SHALL equal (state != EMPTY); the outputs SHALL always present the main entry.
REQ-023 In EMPTY, a push SHALL load main and go to ONE; the beat SHALL be visible on the outputs the cycle after the accepting edge (latency 1).
REQ-024 In ONE: push and pop together SHALL load main from the input and stay in ONE; push alone SHALL load skid and go to TWO; pop alone SHALL go to EMPTY.
REQ-025 In TWO: a pop SHALL copy skid into main and go to ONE; no push is possible.
REQ-026 Beats SHALL leave in acceptance order, with no loss or duplication.
REQ-027 flush SHALL take priority over push and pop: the state goes to EMPTY, any same-cycle input beat is discarded, and control_out is forced to 0; the data fields need not be cleared.
REQ-028 With hit=0, no push SHALL occur regardless of in_valid; pops SHALL proceed.
REQ-029 While state is EMPTY, control_out SHALL be 0, so a bubble never asserts reg_write.
REQ-030 stall_cnt SHALL increment by 1 on every cycle with out_valid && !out_ready, saturate at all-ones, and be cleared only by reset.
REQ-031 Output fields SHALL be registered, with no combinational path from any input to any output except through state.

Reset
REQ-032 While rst_n=0, regardless of clk: state=EMPTY, out_valid=0, in_ready=1, all data outputs 0, control_out=0, stall_cnt=0.
REQ-033 Reset asserted mid-operation SHALL discard all held beats immediately; the first push SHALL be accepted on the first rising edge after rst_n rises.

Verification
REQ-034 Reset, then push alu_result=0x0000_00A5, read_data=0x1234_5678, write_register=5'd7, control=2'b11 with out_ready=1 -> out_valid=1 one cycle later with those values; the next cycle out_valid=0 and control_out=0.
REQ-035 With out_ready=0, push beats A=0x1 then B=0x2 -> in_ready=0 after the second push, stall_cnt increments each cycle; raise out_ready -> A, then B, each for one cycle, and in_ready=1 again.
REQ-036 State ONE, push C=0x3 and pop in the same cycle -> head becomes C, state stays ONE, in_ready stays 1.
REQ-037 State TWO, flush=1 together with in_valid=1 and hit=1 -> next cycle out_valid=0, control_out=0, in_ready=1, and the input beat is never output.
REQ-038 in_valid=1, hit=0 for 3 cycles -> no beat accepted; then hit=1 -> exactly one beat accepted.
REQ-039 CNT_W=2, hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt reaches 3 and stays at 3; then rst_n=0 asynchronously mid-cycle -> all outputs reset without a clock edge.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Purpose: two-entry write-back pipeline stage (main + skid) with flush and stall counting.
// Latency: 1 cycle from accepting edge to head outputs; full throughput with out_ready held high.
// Backpressure: in_ready decoded from registered occupancy only; drops to 0 when both entries are held.
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hit,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] read_data,
    input  logic [REG_W-1:0]  write_register,
    input  logic [CTRL_W-1:0] control,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] read_data_out,
    output logic [REG_W-1:0]  write_register_out,
    output logic [CTRL_W-1:0] control_out,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic push;
    logic pop;

    // Load controls produced by the next-state logic
    logic ld_main_in;
    logic ld_main_skid;
    logic ld_skid;
    logic clr_main_ctrl;

    // Skid entry storage
    logic [DATA_W-1:0] skid_alu;
    logic [DATA_W-1:0] skid_rd;
    logic [REG_W-1:0]  skid_wr;
    logic [CTRL_W-1:0] skid_ctrl;

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    // A flushed cycle never accepts, so the incoming beat is dropped
    assign push      = in_valid && hit && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    // Occupancy register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next occupancy and entry load selection; flush overrides push and pop
    always_comb begin
        state_d       = state_q;
        ld_main_in    = 1'b0;
        ld_main_skid  = 1'b0;
        ld_skid       = 1'b0;
        clr_main_ctrl = 1'b0;
        if (flush) begin
            state_d       = EMPTY;
            clr_main_ctrl = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        ld_main_in = 1'b1;
                        state_d    = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        ld_main_in = 1'b1;
                    end else if (push) begin
                        ld_skid = 1'b1;
                        state_d = TWO;
                    end else if (pop) begin
                        clr_main_ctrl = 1'b1;
                        state_d       = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        ld_main_skid = 1'b1;
                        state_d      = ONE;
                    end
                end
                default: begin
                    clr_main_ctrl = 1'b1;
                    state_d       = EMPTY;
                end
            endcase
        end
    end

    // Main (head) entry drives the outputs directly; control is zeroed whenever the stage empties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result_out     <= '0;
            read_data_out      <= '0;
            write_register_out <= '0;
            control_out        <= '0;
        end else if (ld_main_in) begin
            alu_result_out     <= alu_result;
            read_data_out      <= read_data;
            write_register_out <= write_register;
            control_out        <= control;
        end else if (ld_main_skid) begin
            alu_result_out     <= skid_alu;
            read_data_out      <= skid_rd;
            write_register_out <= skid_wr;
            control_out        <= skid_ctrl;
        end else if (clr_main_ctrl) begin
            control_out        <= '0;
        end
    end

    // Skid entry captures the beat accepted while the head is still waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_alu  <= '0;
            skid_rd   <= '0;
            skid_wr   <= '0;
            skid_ctrl <= '0;
        end else if (ld_skid) begin
            skid_alu  <= alu_result;
            skid_rd   <= read_data;
            skid_wr   <= write_register;
            skid_ctrl <= control;
        end
    end

    // Saturating count of cycles the head is held back by write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hit, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] alu_result, read_data, alu_result_out, read_data_out;
    logic [4:0]  write_register, write_register_out;
    logic [1:0]  control, control_out;
    logic [15:0] stall_cnt;

    // Second instance with a narrow counter for saturation
    logic        s_rst_n, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic        s_hit, s_flush;
    logic [31:0] s_alu, s_rd, s_alu_out, s_rd_out;
    logic [4:0]  s_wr, s_wr_out;
    logic [1:0]  s_ctl, s_ctl_out, s_stall;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_skid u_dut (
        .clk(clk), .rst_n(rst_n), .hit(hit), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .read_data(read_data), .write_register(write_register),
        .control(control), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_result_out(alu_result_out), .read_data_out(read_data_out),
        .write_register_out(write_register_out), .control_out(control_out), .stall_cnt(stall_cnt)
    );

    pipe_stage_skid #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(s_rst_n), .hit(s_hit), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .alu_result(s_alu), .read_data(s_rd), .write_register(s_wr),
        .control(s_ctl), .flush(s_flush), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .alu_result_out(s_alu_out), .read_data_out(s_rd_out),
        .write_register_out(s_wr_out), .control_out(s_ctl_out), .stall_cnt(s_stall)
    );

    typedef struct packed {
        logic        iv, ht, fl, ordy;
        logic [31:0] alu, rd;
        logic [4:0]  wr;
        logic [1:0]  ctl;
        logic        e_ov, e_ir, e_chk;
        logic [31:0] e_alu, e_rd;
        logic [4:0]  e_wr;
        logic [1:0]  e_ctl;
        logic [15:0] e_stall;
    } vec_t;

    typedef struct packed {
        logic [31:0] alu, rd;
        logic [4:0]  wr;
        logic [1:0]  ctl;
    } beat_t;

    vec_t  vecs[18];
    beat_t q[$];
    int    cnt;

    function automatic vec_t mk(logic iv, logic ht, logic fl, logic ordy,
                                logic [31:0] alu, logic [31:0] rd, logic [4:0] wr, logic [1:0] ctl,
                                logic e_ov, logic e_ir, logic e_chk,
                                logic [31:0] e_alu, logic [31:0] e_rd, logic [4:0] e_wr,
                                logic [1:0] e_ctl, logic [15:0] e_stall);
        vec_t v;
        v.iv = iv; v.ht = ht; v.fl = fl; v.ordy = ordy;
        v.alu = alu; v.rd = rd; v.wr = wr; v.ctl = ctl;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_chk = e_chk;
        v.e_alu = e_alu; v.e_rd = e_rd; v.e_wr = e_wr; v.e_ctl = e_ctl; v.e_stall = e_stall;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic ht, input logic fl, input logic ordy,
                         input logic [31:0] alu, input logic [31:0] rd,
                         input logic [4:0] wr, input logic [1:0] ctl);
        in_valid = iv; hit = ht; flush = fl; out_ready = ordy;
        alu_result = alu; read_data = rd; write_register = wr; control = ctl;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ov"},    64'(out_valid), 64'd0);
        chk({tag, "_ir"},    64'(in_ready), 64'd1);
        chk({tag, "_alu"},   64'(alu_result_out), 64'd0);
        chk({tag, "_rd"},    64'(read_data_out), 64'd0);
        chk({tag, "_wr"},    64'(write_register_out), 64'd0);
        chk({tag, "_ctl"},   64'(control_out), 64'd0);
        chk({tag, "_stall"}, 64'(stall_cnt), 64'd0);
    endtask

    initial begin
        // Directed vectors: inputs applied before an edge, expectations sampled after it
        vecs[0]  = mk(1,1,0,1, 32'hA5, 32'h1234_5678, 5'd7, 2'b11, 1,1,1, 32'hA5, 32'h1234_5678, 5'd7, 2'b11, 0);
        vecs[1]  = mk(0,1,0,1, 0, 0, 0, 0,                          0,1,0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1,1,0,0, 32'h1, 32'h11, 5'd1, 2'd1,           1,1,1, 32'h1, 32'h11, 5'd1, 2'd1, 0);
        vecs[3]  = mk(1,1,0,0, 32'h2, 32'h22, 5'd2, 2'd2,           1,0,1, 32'h1, 32'h11, 5'd1, 2'd1, 1);
        vecs[4]  = mk(0,1,0,0, 0, 0, 0, 0,                          1,0,1, 32'h1, 32'h11, 5'd1, 2'd1, 2);
        vecs[5]  = mk(0,1,0,1, 0, 0, 0, 0,                          1,1,1, 32'h2, 32'h22, 5'd2, 2'd2, 2);
        vecs[6]  = mk(0,1,0,1, 0, 0, 0, 0,                          0,1,0, 0, 0, 0, 0, 2);
        vecs[7]  = mk(1,1,0,0, 32'h10, 32'h110, 5'h10, 2'd1,        1,1,1, 32'h10, 32'h110, 5'h10, 2'd1, 2);
        vecs[8]  = mk(1,1,0,1, 32'h3, 32'h33, 5'd3, 2'd3,           1,1,1, 32'h3, 32'h33, 5'd3, 2'd3, 2);
        vecs[9]  = mk(1,1,0,0, 32'h4, 32'h44, 5'd4, 2'd2,           1,0,1, 32'h3, 32'h33, 5'd3, 2'd3, 3);
        vecs[10] = mk(1,1,1,0, 32'h5, 32'h55, 5'd5, 2'd3,           0,1,0, 0, 0, 0, 0, 4);
        vecs[11] = mk(0,1,0,1, 0, 0, 0, 0,                          0,1,0, 0, 0, 0, 0, 4);
        vecs[12] = mk(1,0,0,0, 32'h6, 32'h66, 5'd6, 2'd1,           0,1,0, 0, 0, 0, 0, 4);
        vecs[13] = mk(1,0,0,0, 32'h6, 32'h66, 5'd6, 2'd1,           0,1,0, 0, 0, 0, 0, 4);
        vecs[14] = mk(1,0,0,0, 32'h6, 32'h66, 5'd6, 2'd1,           0,1,0, 0, 0, 0, 0, 4);
        vecs[15] = mk(1,1,0,0, 32'h6, 32'h66, 5'd6, 2'd1,           1,1,1, 32'h6, 32'h66, 5'd6, 2'd1, 4);
        vecs[16] = mk(0,1,0,1, 0, 0, 0, 0,                          0,1,0, 0, 0, 0, 0, 4);
        vecs[17] = mk(0,1,0,1, 0, 0, 0, 0,                          0,1,0, 0, 0, 0, 0, 4);

        rst_n = 1'b0;
        drive(0, 1, 0, 1, 0, 0, 0, 0);
        s_rst_n = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0; s_hit = 1'b1; s_flush = 1'b0;
        s_alu = 32'h77; s_rd = 32'h88; s_wr = 5'd9; s_ctl = 2'b01;

        #2;
        chk_reset_outputs("reset");
        #10;
        rst_n = 1'b1;
        s_rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].iv, vecs[i].ht, vecs[i].fl, vecs[i].ordy,
                  vecs[i].alu, vecs[i].rd, vecs[i].wr, vecs[i].ctl);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_ov", i),    64'(out_valid), 64'(vecs[i].e_ov));
            chk($sformatf("vec%0d_ir", i),    64'(in_ready), 64'(vecs[i].e_ir));
            chk($sformatf("vec%0d_ctl", i),   64'(control_out), 64'(vecs[i].e_ctl));
            chk($sformatf("vec%0d_stall", i), 64'(stall_cnt), 64'(vecs[i].e_stall));
            if (vecs[i].e_chk) begin
                chk($sformatf("vec%0d_alu", i), 64'(alu_result_out), 64'(vecs[i].e_alu));
                chk($sformatf("vec%0d_rd", i),  64'(read_data_out), 64'(vecs[i].e_rd));
                chk($sformatf("vec%0d_wr", i),  64'(write_register_out), 64'(vecs[i].e_wr));
            end
        end

        // Fill both entries, then assert reset between edges: everything clears without a clock
        drive(1, 1, 0, 0, 32'hAA, 32'hBB, 5'd10, 2'd3);
        @(posedge clk); #1;
        drive(1, 1, 0, 0, 32'hCC, 32'hDD, 5'd11, 2'd2);
        @(posedge clk); #1;
        chk("pre_arst_ir", 64'(in_ready), 64'd0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("arst");

        // First push after release is accepted on the first rising edge
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 0, 0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd19, 2'd2);
        @(posedge clk); #1;
        chk("post_rst_ov",  64'(out_valid), 64'd1);
        chk("post_rst_alu", 64'(alu_result_out), 64'hDEAD_BEEF);
        chk("post_rst_ctl", 64'(control_out), 64'd2);

        // Randomized traffic against a queue-based model
        q.delete();
        q.push_back('{alu: 32'hDEAD_BEEF, rd: 32'hCAFE_F00D, wr: 5'd19, ctl: 2'd2});
        cnt = 0;
        for (int i = 0; i < 1500; i++) begin
            logic  iv, ht, fl, ordy, acc;
            beat_t b;
            chk("rnd_ov",    64'(out_valid), 64'(q.size() != 0));
            chk("rnd_ir",    64'(in_ready), 64'(q.size() < 2));
            chk("rnd_stall", 64'(stall_cnt), 64'(cnt));
            if (q.size() != 0) begin
                chk("rnd_alu", 64'(alu_result_out), 64'(q[0].alu));
                chk("rnd_rd",  64'(read_data_out), 64'(q[0].rd));
                chk("rnd_wr",  64'(write_register_out), 64'(q[0].wr));
                chk("rnd_ctl", 64'(control_out), 64'(q[0].ctl));
            end else begin
                chk("rnd_ctl_empty", 64'(control_out), 64'd0);
            end

            iv   = ($urandom_range(0, 3) != 0);
            ht   = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 31) == 0);
            ordy = $urandom_range(0, 1) == 1;
            b.alu = $urandom; b.rd = $urandom;
            b.wr = 5'($urandom); b.ctl = 2'($urandom);
            drive(iv, ht, fl, ordy, b.alu, b.rd, b.wr, b.ctl);

            if (q.size() != 0 && !ordy && cnt < 65535) cnt++;
            if (fl) begin
                q.delete();
            end else begin
                acc = iv && ht && (q.size() < 2);
                if (q.size() != 0 && ordy) void'(q.pop_front());
                if (acc) q.push_back(b);
            end
            @(posedge clk); #1;
        end

        // Narrow counter saturates at all-ones and only reset clears it
        s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        chk("sat_ov", 64'(s_out_valid), 64'd1);
        chk("sat_stall0", 64'(s_stall), 64'd0);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("sat_stall%0d", k), 64'(s_stall), 64'((k > 3) ? 3 : k));
        end
        #3;
        s_rst_n = 1'b0;
        #1;
        chk("sat_arst_ov",    64'(s_out_valid), 64'd0);
        chk("sat_arst_ir",    64'(s_in_ready), 64'd1);
        chk("sat_arst_stall", 64'(s_stall), 64'd0);
        chk("sat_arst_ctl",   64'(s_ctl_out), 64'd0);
        chk("sat_arst_alu",   64'(s_alu_out), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
